// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: RISC-V load/store
// size codes, the handshake FSM encoding and the access-size decoder.
package dmem_pkg;

    // RISC-V funct3 codes for loads/stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Handshake FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Access size in bytes; the low two funct3 bits carry the size for
    // both signed and unsigned codes. Code 111 decodes as 8 but is
    // rejected as illegal elsewhere.
    function automatic logic [3:0] size_of(input logic [2:0] funct3);
        logic [3:0] sz;
        case (funct3[1:0])
            2'b00:   sz = 4'd1;
            2'b01:   sz = 4'd2;
            2'b10:   sz = 4'd4;
            default: sz = 4'd8;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational access decoder: legality, alignment and range checks,
// store byte enables and load-data extension for one request.
module dmem_align
    import dmem_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned DEPTH_BYTES = 1024
) (
    input  logic            write_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [63:0]     rbytes_i,
    output logic [7:0]      be_o,
    output logic [63:0]     wbytes_o,
    output logic            misaligned_o,
    output logic            fault_o,
    output logic [XLEN-1:0] rdata_o
);

    localparam int unsigned AXW = XLEN + 1;

    logic [3:0]   size;
    logic         illegal;
    logic         mis;
    logic         oor;
    logic         ok;
    logic         sbit;
    logic         fill;
    logic [AXW-1:0] end_addr;

    // Decode legality, alignment and range; the end address is formed one
    // bit wider than XLEN so a wrapped sum can never look in range.
    always_comb begin
        size     = size_of(funct3_i);
        illegal  = (funct3_i == 3'b111)
                 || (write_i && funct3_i[2])
                 || ((XLEN == 32) && ((funct3_i == F3_D) || (funct3_i == F3_WU)));
        end_addr = {1'b0, addr_i} + AXW'(size);
        oor      = end_addr > AXW'(DEPTH_BYTES);
        mis      = |(addr_i[2:0] & 3'(size - 4'd1));
        ok       = !illegal && !mis && !oor;

        misaligned_o = !illegal && mis;
        fault_o      = illegal || oor;
    end

    // Store byte enables, lane k of the access maps to address addr+k
    always_comb begin
        be_o     = '0;
        wbytes_o = 64'(wdata_i);
        for (int unsigned k = 0; k < 8; k++) begin
            be_o[k] = ok && write_i && (k < 32'(size));
        end
    end

    // Load extension: copy the accessed bytes, fill the rest with the sign
    // bit for signed codes or zero for unsigned codes
    always_comb begin
        case (size)
            4'd1:    sbit = rbytes_i[7];
            4'd2:    sbit = rbytes_i[15];
            4'd4:    sbit = rbytes_i[31];
            default: sbit = rbytes_i[63];
        endcase
        fill    = !funct3_i[2] && sbit;
        rdata_o = '0;
        for (int unsigned k = 0; k < XLEN / 8; k++) begin
            if (k < 32'(size)) begin
                rdata_o[8*k +: 8] = rbytes_i[8*k +: 8];
            end else begin
                rdata_o[8*k +: 8] = {8{fill}};
            end
        end
        if (write_i || !ok) begin
            rdata_o = '0;
        end
    end

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressed little-endian data memory for the MEM stage with a
// single-outstanding request/response handshake and configurable latency.
module data_memory_lsu
    import dmem_pkg::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned DEPTH_BYTES  = 1024,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_misaligned,
    output logic            rsp_fault
);

    localparam int unsigned AW       = $clog2(DEPTH_BYTES);
    localparam logic [1:0]  LAST_CNT = 2'(READ_LATENCY - 1);

    state_t          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [7:0]      mem [DEPTH_BYTES];

    logic            accept;
    logic [63:0]     rbytes;
    logic [63:0]     wbytes;
    logic [7:0]      be;
    logic [XLEN-1:0] a_rdata;
    logic            a_mis;
    logic            a_fault;

    logic [XLEN-1:0] pend_rdata_q;
    logic            pend_mis_q;
    logic            pend_fault_q;
    logic [XLEN-1:0] rsp_rdata_q;
    logic            rsp_mis_q;
    logic            rsp_fault_q;

    assign accept    = (state_q == IDLE) && req_valid;
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);

    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_misaligned = rsp_mis_q;
    assign rsp_fault      = rsp_fault_q;

    // Gather the eight bytes starting at the request address (index wraps
    // inside the array; out-of-range accesses discard the data anyway)
    always_comb begin
        rbytes = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            rbytes[8*k +: 8] = mem[req_addr[AW-1:0] + AW'(k)];
        end
    end

    dmem_align #(
        .XLEN        (XLEN),
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_align (
        .write_i      (req_write),
        .funct3_i     (req_funct3),
        .addr_i       (req_addr),
        .wdata_i      (req_wdata),
        .rbytes_i     (rbytes),
        .be_o         (be),
        .wbytes_o     (wbytes),
        .misaligned_o (a_mis),
        .fault_o      (a_fault),
        .rdata_o      (a_rdata)
    );

    // Byte-granular store commit on the acceptance edge; contents are not reset
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < 8; k++) begin
            if (accept && be[k]) begin
                mem[req_addr[AW-1:0] + AW'(k)] <= wbytes[8*k +: 8];
            end
        end
    end

    // FSM state and latency counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE accepts, WAIT counts out the latency, RESP pulses once
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cnt_d   = '0;
                    state_d = (READ_LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_d == LAST_CNT) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Capture results at acceptance and publish them on entry to RESP; the
    // single-cycle latency path publishes straight from the decoder since
    // acceptance and RESP entry happen on the same edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_rdata_q <= '0;
            pend_mis_q   <= 1'b0;
            pend_fault_q <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_mis_q    <= 1'b0;
            rsp_fault_q  <= 1'b0;
        end else begin
            if (accept) begin
                pend_rdata_q <= a_rdata;
                pend_mis_q   <= a_mis;
                pend_fault_q <= a_fault;
            end
            if ((state_d == RESP) && (state_q != RESP)) begin
                if (state_q == IDLE) begin
                    rsp_rdata_q <= a_rdata;
                    rsp_mis_q   <= a_mis;
                    rsp_fault_q <= a_fault;
                end else begin
                    rsp_rdata_q <= pend_rdata_q;
                    rsp_mis_q   <= pend_mis_q;
                    rsp_fault_q <= pend_fault_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu (XLEN=64, 1 KiB, three-cycle latency).
module tb_data_memory_lsu;
    import dmem_pkg::*;

    localparam int unsigned XLEN = 64;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned RL = 3;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_write = 1'b0;
    logic [2:0]      req_funct3 = 3'b000;
    logic [XLEN-1:0] req_addr = '0;
    logic [XLEN-1:0] req_wdata = '0;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_misaligned;
    logic            rsp_fault;

    typedef struct {
        logic [63:0] rdata;
        logic        mis;
        logic        fault;
    } exp_t;

    exp_t sb_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    data_memory_lsu #(
        .XLEN         (XLEN),
        .DEPTH_BYTES  (DEPTH),
        .READ_LATENCY (RL)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_misaligned (rsp_misaligned),
        .rsp_fault      (rsp_fault)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge, then wait for its response and compare
    // against the scoreboard entry pushed when it was driven.
    task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wd,
                          input logic [63:0] er, input logic em, input logic ef);
        int unsigned w;
        int unsigned lat;
        exp_t e;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_ready"}, 64'(req_ready), 64'd1);
        sb_q.push_back('{er, em, ef});
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(RL));
        e = sb_q.pop_front();
        check({tag, "_rdata"}, rsp_rdata, e.rdata);
        check({tag, "_mis"}, 64'(rsp_misaligned), 64'(e.mis));
        check({tag, "_fault"}, 64'(rsp_fault), 64'(e.fault));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        int unsigned pulses;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_rdata", rsp_rdata, 64'd0);
        check("rst_mis", 64'(rsp_misaligned), 64'd0);
        check("rst_fault", 64'(rsp_fault), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Doubleword round trip and narrower loads of the same bytes
        do_req("sd10", 1'b1, F3_D, 64'h10, 64'h8877665544332211, 64'd0, 1'b0, 1'b0);
        do_req("ld10", 1'b0, F3_D, 64'h10, 64'd0, 64'h8877665544332211, 1'b0, 1'b0);
        do_req("lb17", 1'b0, F3_B, 64'h17, 64'd0, 64'hFFFFFFFFFFFFFF88, 1'b0, 1'b0);
        do_req("lbu17", 1'b0, F3_BU, 64'h17, 64'd0, 64'h0000000000000088, 1'b0, 1'b0);
        do_req("lh16", 1'b0, F3_H, 64'h16, 64'd0, 64'hFFFFFFFFFFFF8877, 1'b0, 1'b0);
        do_req("lwu14", 1'b0, F3_WU, 64'h14, 64'd0, 64'h0000000088776655, 1'b0, 1'b0);

        // Byte store touches only its byte; high wdata bits must be ignored
        do_req("sb11", 1'b1, F3_B, 64'h11, 64'h123456789ABCDEAA, 64'd0, 1'b0, 1'b0);
        do_req("ld10b", 1'b0, F3_D, 64'h10, 64'd0, 64'h887766554433AA11, 1'b0, 1'b0);
        do_req("lh10", 1'b0, F3_H, 64'h10, 64'd0, 64'hFFFFFFFFFFFFAA11, 1'b0, 1'b0);
        do_req("lw10", 1'b0, F3_W, 64'h10, 64'd0, 64'h000000004433AA11, 1'b0, 1'b0);

        // Misalignment and illegal-store codes leave memory untouched
        do_req("lw12", 1'b0, F3_W, 64'h12, 64'd0, 64'd0, 1'b1, 1'b0);
        do_req("sh13", 1'b1, F3_H, 64'h13, 64'h000000000000BEEF, 64'd0, 1'b1, 1'b0);
        do_req("sw_f3bu", 1'b1, F3_BU, 64'h10, 64'h00000000000000EE, 64'd0, 1'b0, 1'b1);
        do_req("ld10c", 1'b0, F3_D, 64'h10, 64'd0, 64'h887766554433AA11, 1'b0, 1'b0);

        // Range boundaries
        do_req("sd3f8", 1'b1, F3_D, 64'h3F8, 64'h0123456789ABCDEF, 64'd0, 1'b0, 1'b0);
        do_req("ld3f8", 1'b0, F3_D, 64'h3F8, 64'd0, 64'h0123456789ABCDEF, 1'b0, 1'b0);
        do_req("ld400", 1'b0, F3_D, 64'h400, 64'd0, 64'd0, 1'b0, 1'b1);
        do_req("ldwrap", 1'b0, F3_D, 64'hFFFFFFFFFFFFFFF8, 64'd0, 64'd0, 1'b0, 1'b1);
        do_req("lw3fe", 1'b0, F3_W, 64'h3FE, 64'd0, 64'd0, 1'b1, 1'b1);
        do_req("f3_111", 1'b0, 3'b111, 64'h10, 64'd0, 64'd0, 1'b0, 1'b1);

        // Back-to-back requests with req_valid held high
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = F3_D;
        req_addr   = 64'h10;
        for (int i = 0; i < 8; i++) begin
            check("bb_ready", 64'(req_ready), 64'((i % 4) == 0));
            check("bb_valid", 64'(rsp_valid), 64'((i % 4) == 3));
            if ((i % 4) == 3) begin
                check("bb_rdata", rsp_rdata, 64'h887766554433AA11);
            end
            if (i == 7) begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end

        // Reset during WAIT after a store was accepted
        check("pre_rst_ready", 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = F3_D;
        req_addr   = 64'h20;
        req_wdata  = 64'hCAFEF00D12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("wait_ready", 64'(req_ready), 64'd0);
        rstn = 1'b0;
        #1;
        check("mid_rst_ready", 64'(req_ready), 64'd1);
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_rdata", rsp_rdata, 64'd0);
        check("mid_rst_flags", {62'd0, rsp_misaligned, rsp_fault}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("dropped_rsp", 64'(pulses), 64'd0);
        do_req("ld20", 1'b0, F3_D, 64'h20, 64'd0, 64'hCAFEF00D12345678, 1'b0, 1'b0);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
